arp_learner: RTL

- Snoops the router ingress AXI-Stream for ARP replies and extracts sender IP and sender MAC.
- Writes those bindings into the output-port-lookup ARP table through the table write port (tbl_wr_req/addr/data, tbl_wr_ack). It acts as the writer for the table's lookup side.
- Sits in-line ahead of the lookup stage; the stream passes through unmodified and with zero latency.

---
 rtl/arp_learner_pkg.sv | 38 +++
 rtl/fallthrough_small_fifo.sv | 59 +++++
 rtl/arp_learner.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/arp_learner_pkg.sv
// rtl/arp_learner_pkg.sv - shared ARP constants, beat field positions and entry layouts
package arp_learner_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [15:0] ARP_HLEN_PLEN = 16'h0604;

  // Bit offsets of the fields of interest within the first 256-bit beat
  localparam int ETH_TYPE_LSB      = 144;
  localparam int ARP_HLEN_PLEN_LSB = 96;
  localparam int ARP_OP_LSB        = 80;
  localparam int SENDER_MAC_LSB    = 32;
  localparam int SENDER_IP_LSB     = 0;

  // Table entry as written through the table write port
  typedef struct packed {
    logic [15:0] pad;
    logic [47:0] mac;
    logic [31:0] ip;
  } arp_entry_t;

  // Pending-queue element
  typedef struct packed {
    logic [31:0] ip;
    logic [47:0] mac;
  } queue_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } wr_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - small first-word-fall-through FIFO
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   din, wr_en      write data / push (ignored when full)
//   rd_en           pop (ignored when empty)
//   dout            head entry, valid whenever empty is low
//   full, empty     occupancy flags
module fallthrough_small_fifo #(
  parameter int WIDTH          = 80,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      push;
  logic                      pop;

  assign full  = (count == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arp_learner.sv
// rtl/arp_learner.sv - snoops ARP replies on the ingress stream and writes IP/MAC bindings to the ARP table
// Ports:
//   AXI_ACLK, AXI_RESET         clock, asynchronous active-high reset
//   S_AXIS_*                    ingress stream (TREADY mirrors M_AXIS_TREADY)
//   M_AXIS_*                    egress stream, combinational copy of S_AXIS_*
//   tbl_wr_req/addr/data        one-cycle table write request, addr/data held until the write completes
//   tbl_wr_ack                  table write acknowledge
//   learn_cnt, update_cnt       new entries written / existing entries refreshed
//   drop_cnt, timeout_cnt       replies dropped on full queue / writes abandoned without ack
module arp_learner
  import arp_learner_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int FIRST_SLOT           = 16,
  parameter int QDEPTH_BITS          = 2,
  parameter int ACK_TIMEOUT          = 15
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              tbl_wr_req,
  output logic [4:0]                        tbl_wr_addr,
  output logic [3*C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
  input  logic                              tbl_wr_ack,
  output logic [31:0]                       learn_cnt,
  output logic [31:0]                       update_cnt,
  output logic [31:0]                       drop_cnt,
  output logic [31:0]                       timeout_cnt
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  // Zero-latency pass-through; the learner never applies backpressure itself
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TUSER  = S_AXIS_TUSER;
  assign M_AXIS_TVALID = S_AXIS_TVALID;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign S_AXIS_TREADY = M_AXIS_TREADY;

  // Parser
  logic        beat_acc;
  logic        in_pkt;
  logic [31:0] sender_ip;
  logic [47:0] sender_mac;
  logic        is_reply;

  assign beat_acc   = S_AXIS_TVALID & M_AXIS_TREADY;
  assign sender_ip  = S_AXIS_TDATA[SENDER_IP_LSB +: 32];
  assign sender_mac = S_AXIS_TDATA[SENDER_MAC_LSB +: 48];
  assign is_reply   = beat_acc && !in_pkt
                   && (S_AXIS_TDATA[ETH_TYPE_LSB +: 16]      == ETH_TYPE_ARP)
                   && (S_AXIS_TDATA[ARP_OP_LSB +: 16]        == ARP_OP_REPLY)
                   && (S_AXIS_TDATA[ARP_HLEN_PLEN_LSB +: 16] == ARP_HLEN_PLEN)
                   && (sender_ip != 32'h0);

  // Pending queue
  queue_entry_t q_din;
  queue_entry_t q_head;
  logic         q_full;
  logic         q_empty;
  logic         q_pop;
  wr_state_t    state;

  assign q_din = '{ip: sender_ip, mac: sender_mac};
  assign q_pop = (state == ST_IDLE) && !q_empty;

  fallthrough_small_fifo #(
    .WIDTH          ($bits(queue_entry_t)),
    .MAX_DEPTH_BITS (QDEPTH_BITS)
  ) u_queue (
    .clk   (AXI_ACLK),
    .reset (AXI_RESET),
    .din   (q_din),
    .wr_en (is_reply),
    .rd_en (q_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Shadow of the learner-owned slots, searched against the queue head
  logic              shadow_valid [FIRST_SLOT:31];
  logic [31:0]       shadow_ip    [FIRST_SLOT:31];
  logic              hit;
  logic [4:0]        hit_idx;
  logic [4:0]        alloc_ptr;
  logic              wr_hit;
  logic [TMR_W-1:0]  timer;

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit     = 1'b0;
    hit_idx = 5'd0;
    for (int k = 31; k >= FIRST_SLOT; k--) begin
      if (shadow_valid[k] && (shadow_ip[k] == q_head.ip)) begin
        hit     = 1'b1;
        hit_idx = 5'(k);
      end
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      in_pkt      <= 1'b0;
      state       <= ST_IDLE;
      tbl_wr_req  <= 1'b0;
      tbl_wr_addr <= 5'd0;
      tbl_wr_data <= '0;
      wr_hit      <= 1'b0;
      timer       <= '0;
      alloc_ptr   <= 5'(FIRST_SLOT);
      learn_cnt   <= 32'd0;
      update_cnt  <= 32'd0;
      drop_cnt    <= 32'd0;
      timeout_cnt <= 32'd0;
      for (int k = FIRST_SLOT; k <= 31; k++) begin
        shadow_valid[k] <= 1'b0;
        shadow_ip[k]    <= 32'd0;
      end
    end else begin
      if (beat_acc) begin
        in_pkt <= !S_AXIS_TLAST;
      end

      if (is_reply && q_full) begin
        drop_cnt <= sat_inc(drop_cnt);
      end

      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            tbl_wr_addr <= hit ? hit_idx : alloc_ptr;
            tbl_wr_data <= arp_entry_t'{pad: 16'h0, mac: q_head.mac, ip: q_head.ip};
            wr_hit      <= hit;
            tbl_wr_req  <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          tbl_wr_req <= 1'b0;
          timer      <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ack wins over an expiring timer in the same cycle
          if (tbl_wr_ack) begin
            shadow_valid[tbl_wr_addr] <= 1'b1;
            shadow_ip[tbl_wr_addr]    <= tbl_wr_data[31:0];
            if (wr_hit) begin
              update_cnt <= sat_inc(update_cnt);
            end else begin
              learn_cnt <= sat_inc(learn_cnt);
              alloc_ptr <= (alloc_ptr == 5'd31) ? 5'(FIRST_SLOT) : alloc_ptr + 5'd1;
            end
            state <= ST_IDLE;
          end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
            timeout_cnt <= sat_inc(timeout_cnt);
            state       <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
